// File: rtl/io_register_bank_pkg.sv
// Shared types and helpers for io_register_bank.
// Holds the FSM state encoding, the address-width helper and the byte-merge function.
package io_register_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Index width for a register count; never narrower than one bit
  function automatic int addr_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  // One byte lane of a strobed write: take the new byte only when its strobe is set
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/io_register_bank_if.sv
// Enable/write/ready access port of io_register_bank.
// The master drives the request; the slave (the bank) returns data, ready and err.
interface io_register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  enable;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [STRB_WIDTH-1:0] strb;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  ready;
  logic                  err;

  modport master (
    output enable, write, addr, strb, data_in,
    input  r_data_out, ready, err
  );

  modport slave (
    input  enable, write, addr, strb, data_in,
    output r_data_out, ready, err
  );
endinterface

// File: rtl/io_register_bank_slot.sv
// io_register_slot: one read/write register with byte-strobe merge.
// With IO_REGISTER_BANK_SHADOW_EN defined, writes land in a shadow copy and
// commit copies shadow to live; otherwise writes go straight to live and commit is unused.
module io_register_slot
  import io_register_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    commit_i,
  output logic [DATA_WIDTH-1:0]   live_o,
  output logic [DATA_WIDTH-1:0]   rd_o
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] merged_d;

  // Post-write value of the bus-visible copy
  always_comb begin
    merged_d = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      merged_d[b*8 +: 8] = merge_byte(rd_o[b*8 +: 8], data_i[b*8 +: 8], strb_i[b]);
    end
  end

`ifdef IO_REGISTER_BANK_SHADOW_EN
  logic [DATA_WIDTH-1:0] shadow_q;
  logic [DATA_WIDTH-1:0] live_q;

  // Shadow takes writes; commit moves the pre-write shadow into live
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow_q <= RESET_VALUE;
      live_q   <= RESET_VALUE;
    end else begin
      if (wr_en_i)  shadow_q <= merged_d;
      if (commit_i) live_q   <= shadow_q;
    end
  end

  assign rd_o   = shadow_q;
  assign live_o = live_q;
`else
  logic [DATA_WIDTH-1:0] live_q;
  logic                  commit_unused;

  assign commit_unused = commit_i;

  // Writes update the live register directly
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      live_q <= RESET_VALUE;
    end else if (wr_en_i) begin
      live_q <= merged_d;
    end
  end

  assign rd_o   = live_q;
  assign live_o = live_q;
`endif

endmodule

// File: rtl/io_register_bank.sv
// io_register_bank: NUM_RW read/write plus NUM_RO read-only registers behind an
// enable/write/ready port. Optional shadow/commit via macro IO_REGISTER_BANK_SHADOW_EN.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for enable; accepts and performs the access
//  ST_ACK  | ready pulses for this one cycle with r_data_out/err valid
//  ST_HOLD | waits for enable low so one request is never issued twice
module io_register_bank
  import io_register_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_RW      = 4,
  parameter int                    NUM_RO      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  io_register_bank_if.slave            bus,
  input  logic                         commit,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_in,
  output logic [NUM_RW*DATA_WIDTH-1:0] r_mem
);
  localparam int ADDR_WIDTH = addr_width(NUM_RW + NUM_RO);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                state_q;
  logic                  ready_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept;
  logic                  rw_hit;
  logic                  ro_hit;
  logic [DATA_WIDTH-1:0] rw_val;
  logic [DATA_WIDTH-1:0] ro_val;
  logic [DATA_WIDTH-1:0] merged_val;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  err_d;

  logic [DATA_WIDTH-1:0] slot_rd [NUM_RW];
  logic [NUM_RW-1:0]     slot_wr;

  assign accept = (state_q == ST_IDLE) && bus.enable;

  // Address decode: which RW slot or RO status word the request targets
  always_comb begin
    rw_hit = 1'b0;
    ro_hit = 1'b0;
    rw_val = '0;
    ro_val = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (bus.addr == ADDR_WIDTH'(i)) begin
        rw_hit = 1'b1;
        rw_val = slot_rd[i];
      end
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (bus.addr == ADDR_WIDTH'(NUM_RW + k)) begin
        ro_hit = 1'b1;
        ro_val = status_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Response data and error for the request being accepted this cycle
  always_comb begin
    merged_val = rw_val;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      merged_val[b*8 +: 8] = merge_byte(rw_val[b*8 +: 8], bus.data_in[b*8 +: 8], bus.strb[b]);
    end
    rdata_d = '0;
    err_d   = 1'b0;
    if (rw_hit) begin
      rdata_d = bus.write ? merged_val : rw_val;
    end else if (ro_hit) begin
      rdata_d = ro_val;
      err_d   = bus.write;
    end else begin
      err_d   = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RW; i++) begin : g_slot
    assign slot_wr[i] = accept && bus.write && (bus.addr == ADDR_WIDTH'(i));

    io_register_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_slot (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .wr_en_i (slot_wr[i]),
      .strb_i  (bus.strb),
      .data_i  (bus.data_in),
      .commit_i(commit),
      .live_o  (r_mem[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_o    (slot_rd[i])
    );
  end

  // Access FSM with registered response outputs, zero outside ACK
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_ACK;
            ready_q <= 1'b1;
            err_q   <= err_d;
            rdata_q <= rdata_d;
          end
        end
        ST_ACK: begin
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!bus.enable) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.err        = err_q;
  assign bus.r_data_out = rdata_q;

endmodule

// File: tb/tb_io_register_bank.sv
// Self-checking bench for io_register_bank (default build; shadow scenario
// runs when IO_REGISTER_BANK_SHADOW_EN is defined).
module tb_io_register_bank;
  localparam int DW  = 32;
  localparam int NRW = 4;
  localparam int NRO = 2;
  localparam int AW  = 3;
  localparam logic [DW-1:0] RV = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit = 1'b0;
  logic [NRO*DW-1:0] status_in = '0;
  logic [NRW*DW-1:0] r_mem;

  int nchk = 0;
  int nbad = 0;

  logic [DW-1:0] m_view [NRW];
  logic [DW-1:0] m_live [NRW];

  io_register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  io_register_bank #(
    .DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_RO(NRO), .RESET_VALUE(RV)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .bus      (bus_if),
    .commit   (commit),
    .status_in(status_in),
    .r_mem    (r_mem)
  );

  always #5 clk = ~clk;

  // Reference: what a single access should return and how it changes the registers
  task automatic model_access(input logic wr, input logic [AW-1:0] a, input logic [3:0] s,
                              input logic [DW-1:0] d, output logic [DW-1:0] erd, output logic ee);
    int ia;
    ia  = int'(a);
    erd = '0;
    ee  = 1'b0;
    if (ia < NRW) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) if (s[b]) m_view[ia][8*b +: 8] = d[8*b +: 8];
`ifndef IO_REGISTER_BANK_SHADOW_EN
        m_live[ia] = m_view[ia];
`endif
      end
      erd = m_view[ia];
    end else if (ia < NRW + NRO) begin
      erd = status_in[(ia-NRW)*DW +: DW];
      ee  = wr;
    end else begin
      ee  = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) begin
      m_view[i] = RV;
      m_live[i] = RV;
    end
  endtask

  // One complete access; status_in is scrambled right after acceptance
  task automatic access(input logic wr, input logic [AW-1:0] a, input logic [3:0] s,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic e,
                        output logic got, output logic idle_nonzero);
    int n;
    @(negedge clk);
    bus_if.enable  = 1'b1;
    bus_if.write   = wr;
    bus_if.addr    = a;
    bus_if.strb    = s;
    bus_if.data_in = d;
    @(posedge clk);
    #1 status_in = {$urandom, $urandom};
    got = 1'b0;
    n   = 0;
    rd  = '0;
    e   = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      if (bus_if.ready) begin
        got = 1'b1;
        rd  = bus_if.r_data_out;
        e   = bus_if.err;
      end
      n++;
    end
    bus_if.enable = 1'b0;
    @(negedge clk);
    idle_nonzero = bus_if.ready | bus_if.err | (|bus_if.r_data_out);
  endtask

  task automatic test_reset();
    bus_if.enable  = 1'b0;
    bus_if.write   = 1'b0;
    bus_if.addr    = '0;
    bus_if.strb    = '0;
    bus_if.data_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    nchk++;
    if (bus_if.ready !== 1'b0) begin nbad++; $display("FAIL reset_ready got=%b exp=0", bus_if.ready); end
    nchk++;
    if (bus_if.r_data_out !== '0) begin nbad++; $display("FAIL reset_rdata got=%h exp=0", bus_if.r_data_out); end
    nchk++;
    if (bus_if.err !== 1'b0) begin nbad++; $display("FAIL reset_err got=%b exp=0", bus_if.err); end
    for (int i = 0; i < NRW; i++) begin
      nchk++;
      if (r_mem[i*DW +: DW] !== RV) begin nbad++; $display("FAIL reset_rmem%0d got=%h exp=%h", i, r_mem[i*DW +: DW], RV); end
    end
    rst = 1'b0;
  endtask

  task automatic test_strobe_write();
    logic [DW-1:0] rd, erd;
    logic e, ee, got, idn;
    model_access(1'b1, 3'd1, 4'b0101, 32'hDEADBEEF, erd, ee);
    access(1'b1, 3'd1, 4'b0101, 32'hDEADBEEF, rd, e, got, idn);
    nchk++;
    if (got !== 1'b1) begin nbad++; $display("FAIL strb_ready got=%b exp=1", got); end
    nchk++;
    if (rd !== erd || erd !== 32'h00AD00EF) begin nbad++; $display("FAIL strb_rdata got=%h exp=%h", rd, erd); end
    nchk++;
    if (e !== 1'b0) begin nbad++; $display("FAIL strb_err got=%b exp=0", e); end
    nchk++;
    if (r_mem[1*DW +: DW] !== m_live[1]) begin nbad++; $display("FAIL strb_rmem1 got=%h exp=%h", r_mem[1*DW +: DW], m_live[1]); end
    nchk++;
    if (idn !== 1'b0) begin nbad++; $display("FAIL strb_idle_zero got=%b exp=0", idn); end
  endtask

  task automatic test_ro();
    logic [DW-1:0] rd, erd;
    logic e, ee, got, idn;
    status_in = {$urandom, 32'h12345678};
    model_access(1'b0, 3'd4, 4'hF, 32'h0, erd, ee);
    access(1'b0, 3'd4, 4'hF, 32'h0, rd, e, got, idn);
    nchk++;
    if (got !== 1'b1 || rd !== 32'h12345678 || rd !== erd) begin nbad++; $display("FAIL ro_read got=%h exp=%h", rd, erd); end
    nchk++;
    if (e !== ee) begin nbad++; $display("FAIL ro_read_err got=%b exp=%b", e, ee); end
    status_in = {$urandom, $urandom};
    model_access(1'b1, 3'd5, 4'hF, $urandom, erd, ee);
    access(1'b1, 3'd5, 4'hF, 32'h5A5A5A5A, rd, e, got, idn);
    nchk++;
    if (got !== 1'b1 || rd !== erd) begin nbad++; $display("FAIL ro_write_rdata got=%h exp=%h", rd, erd); end
    nchk++;
    if (e !== 1'b1) begin nbad++; $display("FAIL ro_write_err got=%b exp=1", e); end
    for (int i = 0; i < NRW; i++) begin
      nchk++;
      if (r_mem[i*DW +: DW] !== m_live[i]) begin nbad++; $display("FAIL ro_write_rmem%0d got=%h exp=%h", i, r_mem[i*DW +: DW], m_live[i]); end
    end
  endtask

  task automatic test_bad_addr_hold();
    logic [DW-1:0] rd, erd;
    logic e, ee;
    int pulses;
    model_access(1'b1, 3'd6, 4'hF, 32'h0, erd, ee);
    @(negedge clk);
    bus_if.enable  = 1'b1;
    bus_if.write   = 1'b1;
    bus_if.addr    = 3'd6;
    bus_if.strb    = 4'hF;
    bus_if.data_in = $urandom;
    pulses = 0;
    rd = 'x;
    e  = 1'bx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_if.ready) begin
        pulses++;
        rd = bus_if.r_data_out;
        e  = bus_if.err;
      end
    end
    bus_if.enable = 1'b0;
    repeat (2) @(negedge clk);
    nchk++;
    if (pulses != 1) begin nbad++; $display("FAIL bad_addr_pulses got=%0d exp=1", pulses); end
    nchk++;
    if (rd !== erd) begin nbad++; $display("FAIL bad_addr_rdata got=%h exp=%h", rd, erd); end
    nchk++;
    if (e !== ee) begin nbad++; $display("FAIL bad_addr_err got=%b exp=%b", e, ee); end
    for (int i = 0; i < NRW; i++) begin
      nchk++;
      if (r_mem[i*DW +: DW] !== m_live[i]) begin nbad++; $display("FAIL bad_addr_rmem%0d got=%h exp=%h", i, r_mem[i*DW +: DW], m_live[i]); end
    end
  endtask

  task automatic test_strb_zero();
    logic [DW-1:0] rd, erd, d;
    logic e, ee, got, idn;
    d = $urandom;
    model_access(1'b1, 3'd1, 4'h0, d, erd, ee);
    access(1'b1, 3'd1, 4'h0, d, rd, e, got, idn);
    nchk++;
    if (got !== 1'b1 || rd !== erd) begin nbad++; $display("FAIL strb0_rdata got=%h exp=%h", rd, erd); end
    nchk++;
    if (e !== 1'b0) begin nbad++; $display("FAIL strb0_err got=%b exp=0", e); end
    nchk++;
    if (r_mem[1*DW +: DW] !== m_live[1]) begin nbad++; $display("FAIL strb0_rmem1 got=%h exp=%h", r_mem[1*DW +: DW], m_live[1]); end
  endtask

  task automatic test_reset_mid_access();
    logic [DW-1:0] rd, erd;
    logic e, ee, got, idn;
    @(negedge clk);
    bus_if.enable  = 1'b1;
    bus_if.write   = 1'b1;
    bus_if.addr    = 3'd0;
    bus_if.strb    = 4'hF;
    bus_if.data_in = 32'hCAFEF00D;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 bus_if.enable = 1'b0;
    @(negedge clk);
    model_reset();
    nchk++;
    if (bus_if.ready !== 1'b0) begin nbad++; $display("FAIL midrst_ready got=%b exp=0", bus_if.ready); end
    nchk++;
    if (r_mem[0 +: DW] !== RV) begin nbad++; $display("FAIL midrst_rmem0 got=%h exp=%h", r_mem[0 +: DW], RV); end
    rst = 1'b0;
    model_access(1'b0, 3'd0, 4'h0, 32'h0, erd, ee);
    access(1'b0, 3'd0, 4'h0, 32'h0, rd, e, got, idn);
    nchk++;
    if (got !== 1'b1 || rd !== erd) begin nbad++; $display("FAIL midrst_readback got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, erd, d;
    logic [AW-1:0] a;
    logic [3:0] s;
    logic wr, e, ee, got, idn;
    for (int it = 0; it < 40; it++) begin
      status_in = {$urandom, $urandom};
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 7));
      s  = 4'($urandom_range(0, 15));
      d  = $urandom;
      model_access(wr, a, s, d, erd, ee);
      access(wr, a, s, d, rd, e, got, idn);
      nchk++;
      if (got !== 1'b1) begin nbad++; $display("FAIL rand%0d_ready got=%b exp=1", it, got); end
      nchk++;
      if (rd !== erd) begin nbad++; $display("FAIL rand%0d_rdata addr=%0d got=%h exp=%h", it, a, rd, erd); end
      nchk++;
      if (e !== ee) begin nbad++; $display("FAIL rand%0d_err addr=%0d got=%b exp=%b", it, a, e, ee); end
      nchk++;
      if (idn !== 1'b0) begin nbad++; $display("FAIL rand%0d_idle_zero got=%b exp=0", it, idn); end
      for (int i = 0; i < NRW; i++) begin
        nchk++;
        if (r_mem[i*DW +: DW] !== m_live[i]) begin nbad++; $display("FAIL rand%0d_rmem%0d got=%h exp=%h", it, i, r_mem[i*DW +: DW], m_live[i]); end
      end
    end
  endtask

`ifdef IO_REGISTER_BANK_SHADOW_EN
  task automatic test_shadow();
    logic [DW-1:0] rd, erd;
    logic e, ee, got, idn;
    int n;
    for (int k = 0; k < 2; k++) begin
      model_access(1'b1, AW'(k), 4'hF, 32'hA, erd, ee);
      access(1'b1, AW'(k), 4'hF, 32'hA, rd, e, got, idn);
    end
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (r_mem[i*DW +: DW] !== m_live[i]) begin nbad++; $display("FAIL shadow_precommit%0d got=%h exp=%h", i, r_mem[i*DW +: DW], m_live[i]); end
    end
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    for (int i = 0; i < NRW; i++) m_live[i] = m_view[i];
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (r_mem[i*DW +: DW] !== 32'hA || m_live[i] !== 32'hA) begin nbad++; $display("FAIL shadow_commit%0d got=%h exp=%h", i, r_mem[i*DW +: DW], m_live[i]); end
    end
    for (int i = 0; i < NRW; i++) m_live[i] = m_view[i];
    model_access(1'b1, 3'd0, 4'hF, 32'hB, erd, ee);
    @(negedge clk);
    bus_if.enable  = 1'b1;
    bus_if.write   = 1'b1;
    bus_if.addr    = 3'd0;
    bus_if.strb    = 4'hF;
    bus_if.data_in = 32'hB;
    commit = 1'b1;
    @(posedge clk);
    #1 commit = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      if (bus_if.ready) got = 1'b1;
      n++;
    end
    bus_if.enable = 1'b0;
    @(negedge clk);
    nchk++;
    if (got !== 1'b1 || r_mem[0 +: DW] !== m_live[0]) begin nbad++; $display("FAIL shadow_commit_write_live got=%h exp=%h", r_mem[0 +: DW], m_live[0]); end
    model_access(1'b0, 3'd0, 4'h0, 32'h0, erd, ee);
    access(1'b0, 3'd0, 4'h0, 32'h0, rd, e, got, idn);
    nchk++;
    if (got !== 1'b1 || rd !== erd || erd !== 32'hB) begin nbad++; $display("FAIL shadow_commit_write_shadow got=%h exp=%h", rd, erd); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_strobe_write();
    test_ro();
    test_bad_addr_hold();
    test_strb_zero();
    test_reset_mid_access();
    test_random();
`ifdef IO_REGISTER_BANK_SHADOW_EN
    test_shadow();
`endif
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
